regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb_if.sv | 36 +++
 rtl/regfile_wb_arb.sv | 152 +++++++++++++++
 tb/tb_regfile_wb_arb.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arb_if.sv
// rtl/regfile_wb_arb_if.sv - writeback requester, register-file write and hazard-check signal bundle
interface regfile_wb_arb_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        haz1;
  logic        haz2;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  chk_addr1, chk_addr2,
    output req0_ready, req1_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output haz1, haz2
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output chk_addr1, chk_addr2,
    input  req0_ready, req1_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  haz1, haz2
  );
endinterface

// File: rtl/regfile_wb_arb.sv
// rtl/regfile_wb_arb.sv - two-requester register-file writeback arbiter with per-requester FIFOs
// Define WBARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module regfile_wb_arb #(
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_arb_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [4:0]    fa_q [2][DEPTH];
  logic [4:0]    fa_d [2][DEPTH];
  logic [31:0]   fd_q [2][DEPTH];
  logic [31:0]   fd_d [2][DEPTH];
  logic [AW-1:0] wp_q [2];
  logic [AW-1:0] wp_d [2];
  logic [AW-1:0] rp_q [2];
  logic [AW-1:0] rp_d [2];
  logic [AW:0]   cnt_q [2];
  logic [AW:0]   cnt_d [2];
  logic          wen_q, wen_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
`ifdef WBARB_RR_EN
  logic          rr_q, rr_d;
`endif

  logic [1:0]    valid_in, ready_w, push, pop, nempty;
  logic [4:0]    addr_in [2];
  logic [31:0]   data_in [2];
  logic          gnt_vld, gnt;
  logic          hit1, hit2;
  logic [AW-1:0] idx;

  always_comb begin
    valid_in   = {bus.req1_valid, bus.req0_valid};
    addr_in[0] = bus.req0_addr;
    addr_in[1] = bus.req1_addr;
    data_in[0] = bus.req0_data;
    data_in[1] = bus.req1_data;
    for (int n = 0; n < 2; n++) begin
      ready_w[n] = rst && (cnt_q[n] != FULL_CNT);
      nempty[n]  = (cnt_q[n] != '0);
    end
  end

  assign bus.req0_ready = ready_w[0];
  assign bus.req1_ready = ready_w[1];

  // gnt selects requester 1 when set; meaningful only while gnt_vld.
  always_comb begin
    gnt_vld = |nempty;
`ifdef WBARB_RR_EN
    if (nempty == 2'b11) gnt = rr_q;
    else                 gnt = ~nempty[0];
`else
    gnt = ~nempty[0];
`endif
    pop = {gnt_vld & gnt, gnt_vld & ~gnt};
  end

  always_comb begin
    fa_d    = fa_q;
    fd_d    = fd_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef WBARB_RR_EN
    rr_d    = rr_q;
`endif
    for (int n = 0; n < 2; n++) begin
      // Writes to x0 are acknowledged but never buffered.
      push[n] = valid_in[n] && ready_w[n] && (addr_in[n] != 5'd0);
      if (push[n]) begin
        fa_d[n][wp_q[n]] = addr_in[n];
        fd_d[n][wp_q[n]] = data_in[n];
        wp_d[n]          = wp_q[n] + 1'b1;
      end
      if (pop[n]) rp_d[n] = rp_q[n] + 1'b1;
      case ({push[n], pop[n]})
        2'b10:   cnt_d[n] = cnt_q[n] + 1'b1;
        2'b01:   cnt_d[n] = cnt_q[n] - 1'b1;
        default: cnt_d[n] = cnt_q[n];
      endcase
    end
    if (gnt_vld) begin
      wen_d   = 1'b1;
      waddr_d = fa_q[gnt][rp_q[gnt]];
      wdata_d = fd_q[gnt][rp_q[gnt]];
`ifdef WBARB_RR_EN
      rr_d    = ~gnt;
`endif
    end
  end

  always_comb begin
    hit1 = wen_q && (waddr_q == bus.chk_addr1);
    hit2 = wen_q && (waddr_q == bus.chk_addr2);
    idx  = '0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rp_q[n] + AW'(i);
        if ((AW+1)'(i) < cnt_q[n]) begin
          if (fa_q[n][idx] == bus.chk_addr1) hit1 = 1'b1;
          if (fa_q[n][idx] == bus.chk_addr2) hit2 = 1'b1;
        end
      end
    end
  end

  assign bus.haz1     = rst && (bus.chk_addr1 != 5'd0) && hit1;
  assign bus.haz2     = rst && (bus.chk_addr2 != 5'd0) && hit2;
  assign bus.rf_wen   = wen_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;

  always_ff @(posedge clk) begin
    fa_q <= fa_d;
    fd_q <= fd_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < 2; n++) begin
        wp_q[n]  <= '0;
        rp_q[n]  <= '0;
        cnt_q[n] <= '0;
      end
      wen_q   <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
`ifdef WBARB_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef WBARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end
endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb/tb_regfile_wb_arb.sv - directed vector bench for regfile_wb_arb (DEPTH=2, either arbitration build)
module tb_regfile_wb_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arb_if bus ();

  regfile_wb_arb #(.DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        sel;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_h1;
    logic        e_h2;
    logic        e_wen;
  } vec_t;

  vec_t vt [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [4:0] a0 [3];
    logic [4:0] a1 [3];
    logic [4:0] exp_seq [6];
    logic [4:0] got [$];
    int i0, i1, cyc, pulses;
    logic acc0, acc1;

    vt[0] = '{1'b0, 5'd1,  32'hdeadbeef, 5'd1,  5'd2,  1'b1, 1'b0, 1'b1};
    vt[1] = '{1'b0, 5'd0,  32'hb105f00d, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd30, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 5'd5,  32'hcafef00d, 5'd4,  5'd5,  1'b0, 1'b1, 1'b1};
    vt[4] = '{1'b0, 5'd17, 32'ha5a5a5a5, 5'd17, 5'd17, 1'b1, 1'b1, 1'b1};

    bus.req0_valid = 1'b0; bus.req0_addr = 5'd0; bus.req0_data = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 32'd0;
    bus.chk_addr1  = 5'd1; bus.chk_addr2 = 5'd2;

    rst = 1'b0;
    step();
    step();
    check("reset rf_wen",   {31'd0, bus.rf_wen},     32'd0);
    check("reset rf_waddr", {27'd0, bus.rf_waddr},   32'd0);
    check("reset rf_wdata", bus.rf_wdata,            32'd0);
    check("reset ready0",   {31'd0, bus.req0_ready}, 32'd0);
    check("reset ready1",   {31'd0, bus.req1_ready}, 32'd0);
    check("reset haz1",     {31'd0, bus.haz1},       32'd0);
    rst = 1'b1;
    step();
    check("post-reset ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("post-reset ready1", {31'd0, bus.req1_ready}, 32'd1);

    // Single writes: hazard while buffered, one rf_wen pulse two edges after acceptance.
    for (int v = 0; v < 5; v++) begin
      bus.chk_addr1 = vt[v].c1;
      bus.chk_addr2 = vt[v].c2;
      if (vt[v].sel) begin
        bus.req1_valid = 1'b1; bus.req1_addr = vt[v].addr; bus.req1_data = vt[v].data;
        check($sformatf("v%0d ready", v), {31'd0, bus.req1_ready}, 32'd1);
      end else begin
        bus.req0_valid = 1'b1; bus.req0_addr = vt[v].addr; bus.req0_data = vt[v].data;
        check($sformatf("v%0d ready", v), {31'd0, bus.req0_ready}, 32'd1);
      end
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check($sformatf("v%0d haz1 queued", v), {31'd0, bus.haz1},   {31'd0, vt[v].e_h1});
      check($sformatf("v%0d haz2 queued", v), {31'd0, bus.haz2},   {31'd0, vt[v].e_h2});
      check($sformatf("v%0d early wen", v),   {31'd0, bus.rf_wen}, 32'd0);
      step();
      check($sformatf("v%0d rf_wen", v), {31'd0, bus.rf_wen}, {31'd0, vt[v].e_wen});
      if (vt[v].e_wen) begin
        check($sformatf("v%0d rf_waddr", v), {27'd0, bus.rf_waddr}, {27'd0, vt[v].addr});
        check($sformatf("v%0d rf_wdata", v), bus.rf_wdata, vt[v].data);
      end
      check($sformatf("v%0d haz1 outreg", v), {31'd0, bus.haz1}, {31'd0, vt[v].e_h1});
      step();
      check($sformatf("v%0d wen drop", v), {31'd0, bus.rf_wen}, 32'd0);
      check($sformatf("v%0d haz1 clear", v), {31'd0, bus.haz1}, 32'd0);
    end

    // Back-to-back writes to the same register keep order.
    bus.chk_addr1  = 5'd1;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h8badf00d;
    step();
    bus.req0_data = 32'hbaadcafe;
    step();
    bus.req0_valid = 1'b0;
    check("b2b first wen",   {31'd0, bus.rf_wen}, 32'd1);
    check("b2b first data",  bus.rf_wdata, 32'h8badf00d);
    step();
    check("b2b second wen",  {31'd0, bus.rf_wen}, 32'd1);
    check("b2b second addr", {27'd0, bus.rf_waddr}, 32'd1);
    check("b2b second data", bus.rf_wdata, 32'hbaadcafe);
    step();
    check("b2b done", {31'd0, bus.rf_wen}, 32'd0);

    // Both requesters streaming three entries each.
    a0 = '{5'd2, 5'd3, 5'd4};
    a1 = '{5'd5, 5'd6, 5'd7};
`ifdef WBARB_RR_EN
    exp_seq = '{5'd2, 5'd5, 5'd3, 5'd6, 5'd4, 5'd7};
`else
    exp_seq = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
`endif
    i0 = 0; i1 = 0; cyc = 0;
    while (got.size() < 6 && cyc < 40) begin
      bus.req0_valid = (i0 < 3);
      bus.req0_addr  = (i0 < 3) ? a0[i0] : 5'd0;
      bus.req0_data  = {27'd0, bus.req0_addr};
      bus.req1_valid = (i1 < 3);
      bus.req1_addr  = (i1 < 3) ? a1[i1] : 5'd0;
      bus.req1_data  = {27'd0, bus.req1_addr};
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      step();
      cyc++;
      if (acc0) i0++;
      if (acc1) i1++;
      if (bus.rf_wen) got.push_back(bus.rf_waddr);
      if (cyc == 2) begin
        check("stream ready1 full", {31'd0, bus.req1_ready}, 32'd0);
        check("stream ready0",      {31'd0, bus.req0_ready}, 32'd1);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("stream pulse count", got.size(), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < got.size()) check($sformatf("stream addr %0d", k), {27'd0, got[k]}, {27'd0, exp_seq[k]});
    end
    step();
    step();

    // Reset while both FIFOs hold data drops everything.
    bus.chk_addr1  = 5'd10; bus.chk_addr2 = 5'd9;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd9;  bus.req0_data = 32'h99;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd10; bus.req1_data = 32'haa;
    step();
    step();
    step();
    check("fill haz1", {31'd0, bus.haz1}, 32'd1);
    rst = 1'b0;
    #1;
    check("in-reset ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("in-reset ready1", {31'd0, bus.req1_ready}, 32'd0);
    check("in-reset haz1",   {31'd0, bus.haz1},       32'd0);
    check("in-reset haz2",   {31'd0, bus.haz2},       32'd0);
    step();
    check("after reset edge wen", {31'd0, bus.rf_wen}, 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.rf_wen) pulses++;
    end
    check("no wen after reset", pulses, 32'd0);
    check("release ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("release ready1", {31'd0, bus.req1_ready}, 32'd1);
    check("release haz1",   {31'd0, bus.haz1},       32'd0);
    check("release haz2",   {31'd0, bus.haz2},       32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
